mem_stage_hs: RTL and testbench
===============================

MEM_STAGE_HS -- requirements
Module: mem_stage_hs

Interface
REQ-001 Parameter DATA_W, default 32, datapath/memory width; legal values 32 or 64.
REQ-002 Parameter RF_AW, default 5, register-file address width.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 in_valid  input  1  EX offers an instruction.
REQ-006 in_ready  output  1  stage accepts the offered instruction this cycle.
REQ-007 in_pc  input  32  instruction PC.
REQ-008 in_op  input  4  memory op code (package enum: NONE, LB, LBU, LH, LHU, LW, SB, SH, SW, LD, SD).
REQ-009 in_ex_result  input  DATA_W  ALU result; it is the byte address for memory ops.
REQ-010 in_wdata  input  DATA_W  store data (low bytes significant).
REQ-011 in_rf_we / in_rf_waddr  input  1 / RF_AW  writeback enable and destination.
REQ-012 mem_req  output  1  memory request, held stable until granted.
REQ-013 mem_gnt  input  1  memory accepts the request.
REQ-014 mem_addr  output  32  word-aligned address (low log2(DATA_W/8) bits zero).
REQ-015 mem_wstrb  output  DATA_W/8  byte write strobes; all-zero means read.
REQ-016 mem_wdata  output  DATA_W  store data replicated into every lane.
REQ-017 mem_rvalid / mem_rdata  input  1 / DATA_W  read response.
REQ-018 out_valid / out_ready  output / input  1 / 1  WB handshake.
REQ-019 out_pc, out_rf_we, out_rf_waddr, out_rf_wdata  output  32, 1, RF_AW, DATA_W  WB payload.
REQ-020 stallreq_for_load  output  1  a load is in flight (REQ or RESP state).

Function
REQ-021 Single-entry slot; FSM states IDLE, REQ, RESP, DONE.
REQ-022 in_ready SHALL equal (state==IDLE) | (state==DONE & out_ready); transfer when in_valid & in_ready.
REQ-023 Accepted op NONE goes to DONE next cycle (latency 1); load/store goes to REQ.
REQ-024 In REQ, mem_req=1 with stable address/strobes/data; on mem_gnt: store -> DONE, load -> RESP.
REQ-025 mem_rvalid is only honoured in RESP (never in the gnt cycle); on it, rdata is captured and state -> DONE.
REQ-026 Minimum load latency: accept cycle 0, gnt cycle 1, rvalid cycle 2, out_valid cycle 3.
REQ-027 Byte offset off = in_ex_result[log2(DATA_W/8)-1:0]; SB strobe 1<<off, SH 3<<(off&~1), SW 0xF<<(off&~3), SD all ones.
REQ-028 Load extraction: LB/LH/LW sign-extend to DATA_W, LBU/LHU zero-extend, LD full width; lane selected by off.
REQ-029 Stores SHALL drive out_rf_we=0; loads write extracted data; NONE writes in_ex_result.
REQ-030 DONE holds out_valid and the payload stable until out_ready; a new accept in the same cycle SHALL replace it back-to-back.
REQ-031 LD/SD when DATA_W=32 SHALL be treated as NONE.

Reset
REQ-032 While rst=0: state IDLE, mem_req=0, out_valid=0, stallreq_for_load=0, all payload registers 0; in-flight transaction dropped and mem_req deasserted immediately.
REQ-033 First accept possible in the first cycle after rst deasserts.

Configuration
REQ-034 MEM_STAGE_MISALIGN_EXC_EN defined: port out_excp (output, 1) exists; a misaligned load/store skips REQ, goes to DONE with out_rf_we=0, out_excp=1. Undefined: no port; misaligned addresses are aligned down (off masked) and executed.

Structure
REQ-035 Op enum, DATA_W-derived lane-width constants, and FSM state type belong in the shared package mem_pkg.
REQ-036 One sub-module, mem_load_align (combinational lane select and extension), instantiated once.

Verification
REQ-037 LB addr 0x1003, rdata 0x80000000 -> out_rf_wdata 0xFFFFFF80, out_valid 2 cycles after gnt.
REQ-038 SH addr 0x2002, wdata 0x1234 -> mem_wstrb 0xC, mem_wdata 0x12341234, out_rf_we 0.
REQ-039 mem_gnt low 5 cycles -> mem_req/mem_addr stable, in_ready 0, stallreq_for_load 1 throughout.
REQ-040 out_ready low 3 cycles in DONE -> payload stable; then back-to-back NONE ops at 1 per cycle.
REQ-041 rst asserted in RESP -> mem_req, out_valid 0 immediately; late rvalid ignored.
REQ-042 LW addr 0x1001 with macro -> out_excp 1, no mem_req; without -> read 0x1000 performed.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory stage: op codes, FSM states, lane geometry.
package mem_pkg;

    typedef enum logic [3:0] {
        NONE = 4'd0,
        LB   = 4'd1,
        LBU  = 4'd2,
        LH   = 4'd3,
        LHU  = 4'd4,
        LW   = 4'd5,
        SB   = 4'd6,
        SH   = 4'd7,
        SW   = 4'd8,
        LD   = 4'd9,
        SD   = 4'd10
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DONE
    } mem_state_e;

    localparam int unsigned BYTE_W = 8;

    function automatic int unsigned lane_bytes(input int unsigned data_w);
        return data_w / BYTE_W;
    endfunction

    function automatic int unsigned off_bits(input int unsigned data_w);
        return $clog2(data_w / BYTE_W);
    endfunction

    function automatic logic is_load(input mem_op_e op);
        return op inside {LB, LBU, LH, LHU, LW, LD};
    endfunction

    function automatic logic is_store(input mem_op_e op);
        return op inside {SB, SH, SW, SD};
    endfunction

    // Byte-offset bits kept after natural alignment of the access size.
    function automatic logic [2:0] size_mask(input mem_op_e op);
        case (op)
            LH, LHU, SH: return 3'b110;
            LW, SW:      return 3'b100;
            LD, SD:      return 3'b000;
            default:     return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_hs_if.sv
// Request/grant/response data-memory port of the memory stage.
interface mem_stage_hs_if #(
    parameter int unsigned DATA_W = 32
);
    logic                  mem_req;
    logic                  mem_gnt;
    logic [31:0]           mem_addr;
    logic [DATA_W/8-1:0]   mem_wstrb;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_rvalid;
    logic [DATA_W-1:0]     mem_rdata;

    modport master (
        output mem_req, mem_addr, mem_wstrb, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_addr, mem_wstrb, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_load_align.sv
// Load lane select and sign/zero extension of a memory read word.
module mem_load_align
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  mem_op_e                        op,
    input  logic [off_bits(DATA_W)-1:0]    off,
    input  logic [DATA_W-1:0]              rdata,
    output logic [DATA_W-1:0]              data
);

    logic [DATA_W-1:0] lane;

    assign lane = rdata >> {off, 3'b000};

    always_comb begin
        data = lane;
        case (op)
            LB:      data = DATA_W'($signed(lane[7:0]));
            LBU:     data = DATA_W'(lane[7:0]);
            LH:      data = DATA_W'($signed(lane[15:0]));
            LHU:     data = DATA_W'(lane[15:0]);
            LW:      data = DATA_W'($signed(lane[31:0]));
            default: data = lane;
        endcase
    end

endmodule

// File: rtl/mem_stage_hs.sv
// Memory stage: single-slot EX->WB handshake with a req/gnt/rvalid data port.
// Define MEM_STAGE_MISALIGN_EXC_EN to trap misaligned accesses on out_excp instead of aligning down.
module mem_stage_hs
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RF_AW  = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_pc,
    input  mem_op_e            in_op,
    input  logic [DATA_W-1:0]  in_ex_result,
    input  logic [DATA_W-1:0]  in_wdata,
    input  logic               in_rf_we,
    input  logic [RF_AW-1:0]   in_rf_waddr,
    mem_stage_hs_if.master     mem,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_pc,
    output logic               out_rf_we,
    output logic [RF_AW-1:0]   out_rf_waddr,
    output logic [DATA_W-1:0]  out_rf_wdata,
`ifdef MEM_STAGE_MISALIGN_EXC_EN
    output logic               out_excp,
`endif
    output logic               stallreq_for_load
);

    localparam int unsigned NB    = lane_bytes(DATA_W);
    localparam int unsigned OFF_W = off_bits(DATA_W);

    mem_state_e          state_q, state_d, accept_target;
    mem_op_e             eff_op, op_q;
    logic [OFF_W-1:0]    off, aoff, aoff_q;
    logic [31:0]         addr_q;
    logic [NB-1:0]       strb, wstrb_q;
    logic [DATA_W-1:0]   wdata_rep, wdata_q, load_data;
    logic                accept, take_exc, mem_op;

    always_comb begin
        eff_op = in_op;
        if (DATA_W == 32 && (in_op == LD || in_op == SD))
            eff_op = NONE;
    end

    assign mem_op = is_load(eff_op) | is_store(eff_op);
    assign off    = in_ex_result[OFF_W-1:0];
    assign aoff   = off & OFF_W'(size_mask(eff_op));

`ifdef MEM_STAGE_MISALIGN_EXC_EN
    assign take_exc = mem_op & (off != aoff);
`else
    assign take_exc = 1'b0;
`endif

    assign accept_target = (mem_op & ~take_exc) ? REQ : DONE;

    always_comb begin
        strb      = '0;
        wdata_rep = '0;
        case (eff_op)
            SB: begin
                strb      = NB'(1) << aoff;
                wdata_rep = {NB{in_wdata[7:0]}};
            end
            SH: begin
                strb      = NB'(2'b11) << aoff;
                wdata_rep = {(NB/2){in_wdata[15:0]}};
            end
            SW: begin
                strb      = NB'(4'hF) << aoff;
                wdata_rep = {(NB/4){in_wdata[31:0]}};
            end
            SD: begin
                strb      = '1;
                wdata_rep = in_wdata;
            end
            default: ;
        endcase
    end

    // A DONE slot drained this cycle may be refilled in the same cycle.
    always_comb begin
        state_d           = state_q;
        in_ready          = 1'b0;
        out_valid         = 1'b0;
        mem.mem_req       = 1'b0;
        stallreq_for_load = 1'b0;
        case (state_q)
            IDLE: in_ready = 1'b1;
            REQ: begin
                mem.mem_req       = 1'b1;
                stallreq_for_load = is_load(op_q);
                if (mem.mem_gnt)
                    state_d = is_load(op_q) ? RESP : DONE;
            end
            RESP: begin
                stallreq_for_load = 1'b1;
                if (mem.mem_rvalid)
                    state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        accept = in_valid & in_ready;
        if (accept)
            state_d = accept_target;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            op_q         <= NONE;
            aoff_q       <= '0;
            addr_q       <= '0;
            wstrb_q      <= '0;
            wdata_q      <= '0;
            out_pc       <= '0;
            out_rf_we    <= 1'b0;
            out_rf_waddr <= '0;
            out_rf_wdata <= '0;
`ifdef MEM_STAGE_MISALIGN_EXC_EN
            out_excp     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q         <= eff_op;
                aoff_q       <= aoff;
                addr_q       <= {in_ex_result[31:OFF_W], {OFF_W{1'b0}}};
                wstrb_q      <= take_exc ? '0 : strb;
                wdata_q      <= wdata_rep;
                out_pc       <= in_pc;
                out_rf_waddr <= in_rf_waddr;
                out_rf_we    <= in_rf_we & ~is_store(eff_op) & ~take_exc;
                out_rf_wdata <= in_ex_result;
`ifdef MEM_STAGE_MISALIGN_EXC_EN
                out_excp     <= take_exc;
`endif
            end else if (state_q == RESP && mem.mem_rvalid) begin
                out_rf_wdata <= load_data;
            end
        end
    end

    assign mem.mem_addr  = addr_q;
    assign mem.mem_wstrb = wstrb_q;
    assign mem.mem_wdata = wdata_q;

    mem_load_align #(
        .DATA_W (DATA_W)
    ) u_load_align (
        .op    (op_q),
        .off   (aoff_q),
        .rdata (mem.mem_rdata),
        .data  (load_data)
    );

endmodule

// File: tb/tb_mem_stage_hs.sv
// Self-checking bench for mem_stage_hs (32-bit datapath) with a behavioural transaction model.
module tb_mem_stage_hs;
    import mem_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     in_pc = '0;
    mem_op_e         in_op = NONE;
    logic [DW-1:0]   in_ex_result = '0;
    logic [DW-1:0]   in_wdata = '0;
    logic            in_rf_we = 1'b0;
    logic [AW-1:0]   in_rf_waddr = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [31:0]     out_pc;
    logic            out_rf_we;
    logic [AW-1:0]   out_rf_waddr;
    logic [DW-1:0]   out_rf_wdata;
    logic            stallreq_for_load;
`ifdef MEM_STAGE_MISALIGN_EXC_EN
    logic            out_excp;
`endif

    int checks = 0;
    int errors = 0;

    mem_stage_hs_if #(.DATA_W(DW)) mem_bus ();

    mem_stage_hs #(.DATA_W(DW), .RF_AW(AW)) dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_pc             (in_pc),
        .in_op             (in_op),
        .in_ex_result      (in_ex_result),
        .in_wdata          (in_wdata),
        .in_rf_we          (in_rf_we),
        .in_rf_waddr       (in_rf_waddr),
        .mem               (mem_bus),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_pc            (out_pc),
        .out_rf_we         (out_rf_we),
        .out_rf_waddr      (out_rf_waddr),
        .out_rf_wdata      (out_rf_wdata),
`ifdef MEM_STAGE_MISALIGN_EXC_EN
        .out_excp          (out_excp),
`endif
        .stallreq_for_load (stallreq_for_load)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // One full transaction from the IDLE slot; expectations come from the access rules.
    task automatic do_txn(input mem_op_e op, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input int gd, input int rdly, input int hold,
                          input logic we, input logic [AW-1:0] wa, input logic [31:0] pc);
        mem_op_e     eop;
        int unsigned sz, off, aoff;
        logic        ld, st, sgn, exc, exp_we;
        logic [63:0] m, v, word, exp_wd;
        logic [3:0]  exp_strb;
        logic [31:0] exp_data, exp_addr;
        eop = (op == LD || op == SD) ? NONE : op;
        case (eop)
            LB, LBU, SB: sz = 1;
            LH, LHU, SH: sz = 2;
            LW, SW:      sz = 4;
            default:     sz = 0;
        endcase
        ld   = eop inside {LB, LBU, LH, LHU, LW};
        st   = eop inside {SB, SH, SW};
        sgn  = eop inside {LB, LH, LW};
        off  = addr % 4;
        aoff = (sz == 0) ? off : off - off % sz;
        exc  = 1'b0;
`ifdef MEM_STAGE_MISALIGN_EXC_EN
        exc  = (ld || st) && (off != aoff);
`endif
        m = (64'd1 << (8 * sz)) - 64'd1;
        v = ({32'd0, rd} >> (8 * aoff)) & m;
        if (sgn && v[8*sz-1]) v = v | ~m;
        exp_strb = st ? 4'(((1 << sz) - 1) << aoff) : 4'h0;
        word   = {32'd0, wd} & m;
        exp_wd = '0;
        if (st) for (int k = 0; k < 4 / int'(sz); k++) exp_wd = exp_wd | (word << (8 * sz * k));
        exp_data = ld ? v[31:0] : addr;
        exp_addr = addr & 32'hFFFF_FFFC;
        exp_we   = we & ~st & ~exc;

        in_valid = 1'b1; in_op = op; in_ex_result = addr; in_wdata = wd;
        in_rf_we = we; in_rf_waddr = wa; in_pc = pc;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL accept_ready: got %b exp 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        if ((ld || st) && !exc) begin
            for (int c = 0; c <= gd; c++) begin
                checks++; if (mem_bus.mem_req !== 1'b1) begin errors++; $display("FAIL req: got %b exp 1", mem_bus.mem_req); end
                checks++; if (mem_bus.mem_addr !== exp_addr) begin errors++; $display("FAIL addr: got %h exp %h", mem_bus.mem_addr, exp_addr); end
                checks++; if (mem_bus.mem_wstrb !== exp_strb) begin errors++; $display("FAIL wstrb: got %h exp %h", mem_bus.mem_wstrb, exp_strb); end
                if (st) begin
                    checks++; if (mem_bus.mem_wdata !== exp_wd[31:0]) begin errors++; $display("FAIL wdata: got %h exp %h", mem_bus.mem_wdata, exp_wd[31:0]); end
                end
                checks++; if (stallreq_for_load !== ld) begin errors++; $display("FAIL stall_req: got %b exp %b", stallreq_for_load, ld); end
                checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL req_hs: got ready %b valid %b exp 0 0", in_ready, out_valid); end
                mem_bus.mem_gnt = (c == gd);
                @(negedge clk);
            end
            mem_bus.mem_gnt = 1'b0;
            if (ld) begin
                for (int c = 0; c <= rdly; c++) begin
                    checks++; if (mem_bus.mem_req !== 1'b0 || stallreq_for_load !== 1'b1 || out_valid !== 1'b0)
                        begin errors++; $display("FAIL resp: got req %b stall %b valid %b exp 0 1 0", mem_bus.mem_req, stallreq_for_load, out_valid); end
                    mem_bus.mem_rvalid = (c == rdly);
                    mem_bus.mem_rdata  = (c == rdly) ? rd : $urandom;
                    @(negedge clk);
                end
                mem_bus.mem_rvalid = 1'b0;
            end
        end
        for (int c = 0; c <= hold; c++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL out_valid: got %b exp 1 (op %s)", out_valid, op.name()); end
            checks++; if (out_pc !== pc || out_rf_waddr !== wa) begin errors++; $display("FAIL out_pc_waddr: got %h %h exp %h %h", out_pc, out_rf_waddr, pc, wa); end
            checks++; if (out_rf_we !== exp_we) begin errors++; $display("FAIL out_we: got %b exp %b", out_rf_we, exp_we); end
            if (!st && !exc) begin
                checks++; if (out_rf_wdata !== exp_data) begin errors++; $display("FAIL out_data: got %h exp %h (op %s addr %h rd %h)", out_rf_wdata, exp_data, op.name(), addr, rd); end
            end
`ifdef MEM_STAGE_MISALIGN_EXC_EN
            checks++; if (out_excp !== exc) begin errors++; $display("FAIL out_excp: got %b exp %b", out_excp, exc); end
`endif
            checks++; if (mem_bus.mem_req !== 1'b0 || stallreq_for_load !== 1'b0 || in_ready !== 1'b0)
                begin errors++; $display("FAIL done_ctl: got req %b stall %b ready %b exp 0 0 0", mem_bus.mem_req, stallreq_for_load, in_ready); end
            out_ready = (c == hold);
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drained: got %b exp 0", out_valid); end
    endtask

    task automatic test_reset();
        mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = '0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (mem_bus.mem_req !== 1'b0 || out_valid !== 1'b0 || stallreq_for_load !== 1'b0)
            begin errors++; $display("FAIL reset_ctl: got req %b valid %b stall %b exp 0 0 0", mem_bus.mem_req, out_valid, stallreq_for_load); end
        checks++; if (out_pc !== '0 || out_rf_wdata !== '0 || out_rf_we !== 1'b0 || out_rf_waddr !== '0)
            begin errors++; $display("FAIL reset_payload: got %h %h %b %h exp 0", out_pc, out_rf_wdata, out_rf_we, out_rf_waddr); end
        rst = 1'b1;
        do_txn(NONE, 32'hCAFE_0001, '0, '0, 0, 0, 0, 1'b1, 5'd3, 32'h0000_0100);
    endtask

    task automatic test_lb_sign();
        do_txn(LB, 32'h0000_1003, '0, 32'h8000_0000, 0, 0, 0, 1'b1, 5'd7, 32'h0000_0200);
        do_txn(LBU, 32'h0000_1003, '0, 32'h8000_0000, 0, 0, 0, 1'b1, 5'd7, 32'h0000_0204);
        do_txn(LH, 32'h0000_1002, '0, 32'h9ABC_0000, 0, 1, 0, 1'b1, 5'd8, 32'h0000_0208);
    endtask

    task automatic test_sh_store();
        do_txn(SH, 32'h0000_2002, 32'h0000_1234, '0, 0, 0, 0, 1'b1, 5'd9, 32'h0000_0300);
        do_txn(SB, 32'h0000_2001, 32'h0000_00A5, '0, 1, 0, 0, 1'b1, 5'd9, 32'h0000_0304);
    endtask

    task automatic test_gnt_stall();
        do_txn(LW, 32'h0000_4008, '0, 32'h1357_9BDF, 5, 2, 1, 1'b1, 5'd10, 32'h0000_0400);
    endtask

    task automatic test_rvalid_with_gnt();
        in_valid = 1'b1; in_op = LW; in_ex_result = 32'h0000_3000; in_rf_we = 1'b1; in_pc = 32'h500;
        @(negedge clk);
        in_valid = 1'b0;
        mem_bus.mem_gnt = 1'b1; mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b0;
        checks++; if (out_valid !== 1'b0 || stallreq_for_load !== 1'b1)
            begin errors++; $display("FAIL gnt_rvalid: got valid %b stall %b exp 0 1", out_valid, stallreq_for_load); end
        mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'h1122_3344;
        @(negedge clk);
        mem_bus.mem_rvalid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_rf_wdata !== 32'h1122_3344)
            begin errors++; $display("FAIL gnt_rvalid_data: got %b %h exp 1 11223344", out_valid, out_rf_wdata); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] pcs [5];
        logic [31:0] res [5];
        for (int k = 0; k < 5; k++) begin pcs[k] = $urandom; res[k] = $urandom; end
        in_valid = 1'b1; in_op = NONE; in_pc = pcs[0]; in_ex_result = res[0]; in_rf_we = 1'b1;
        @(negedge clk);
        in_pc = pcs[1]; in_ex_result = res[1];
        for (int c = 0; c < 3; c++) begin
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_pc !== pcs[0] || out_rf_wdata !== res[0])
                begin errors++; $display("FAIL b2b_hold: got %b %b %h %h exp 1 0 %h %h", out_valid, in_ready, out_pc, out_rf_wdata, pcs[0], res[0]); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            in_pc = pcs[k]; in_ex_result = res[k];
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || out_pc !== pcs[k] || out_rf_wdata !== res[k])
                begin errors++; $display("FAIL b2b_stream%0d: got %b %h %h exp 1 %h %h", k, out_valid, out_pc, out_rf_wdata, pcs[k], res[k]); end
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b exp 0", out_valid); end
    endtask

    task automatic test_reset_inflight();
        in_valid = 1'b1; in_op = LW; in_ex_result = 32'h0000_4000; in_pc = 32'h600; in_rf_we = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (mem_bus.mem_req !== 1'b1) begin errors++; $display("FAIL rst_req_pre: got %b exp 1", mem_bus.mem_req); end
        rst = 1'b0;
        #1;
        checks++; if (mem_bus.mem_req !== 1'b0 || stallreq_for_load !== 1'b0)
            begin errors++; $display("FAIL rst_in_req: got req %b stall %b exp 0 0", mem_bus.mem_req, stallreq_for_load); end
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        mem_bus.mem_gnt = 1'b1;
        @(negedge clk);
        mem_bus.mem_gnt = 1'b0;
        checks++; if (stallreq_for_load !== 1'b1) begin errors++; $display("FAIL rst_resp_pre: got %b exp 1", stallreq_for_load); end
        rst = 1'b0;
        #1;
        checks++; if (mem_bus.mem_req !== 1'b0 || out_valid !== 1'b0 || stallreq_for_load !== 1'b0 || out_pc !== '0)
            begin errors++; $display("FAIL rst_in_resp: got %b %b %b %h exp 0 0 0 0", mem_bus.mem_req, out_valid, stallreq_for_load, out_pc); end
        @(negedge clk);
        rst = 1'b1;
        mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        mem_bus.mem_rvalid = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_rf_wdata !== '0)
            begin errors++; $display("FAIL late_rvalid: got %b %b %h exp 0 1 0", out_valid, in_ready, out_rf_wdata); end
    endtask

    task automatic test_misalign();
        do_txn(LW, 32'h0000_1001, '0, 32'hA1B2_C3D4, 0, 0, 0, 1'b1, 5'd11, 32'h0000_0700);
        do_txn(SW, 32'h0000_1006, 32'h7777_8888, '0, 0, 0, 0, 1'b1, 5'd12, 32'h0000_0704);
        do_txn(LHU, 32'h0000_1003, '0, 32'hF00D_BEEF, 0, 0, 0, 1'b1, 5'd13, 32'h0000_0708);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            do_txn(mem_op_e'($urandom_range(0, 10)), $urandom, $urandom, $urandom,
                   $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 1),
                   1'($urandom), AW'($urandom), $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_lb_sign();
        test_sh_store();
        test_gnt_stall();
        test_rvalid_with_gnt();
        test_back_to_back();
        test_reset_inflight();
        test_misalign();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
